// File: rtl/dir_mapp.sv
// -----------------------------------------------------------------------------
// dir_mapp : 32-line direct-mapped lookup table, one 32-bit word per line.
//
// The input word is both the address and the payload:
//   index = data_in[4:0], tag = data_in[31:5].
//
// Ports
//   clk         in   rising-edge clock for all state
//   rst_n       in   asynchronous active-low reset (clears valid bits, outputs)
//   enable      in   1 = perform the operation selected by read_write
//   read_write  in   1 = write (fill the indexed line), 0 = read (lookup)
//   data_in     in   [31:0] address/data word
//   data_out    out  [31:0] registered lookup result (0 on miss)
//   hit         out  registered, 1 = last lookup hit
//
// Writes always evict whatever the indexed line held. Outputs only change
// on a read; writes and idle cycles leave them holding.
// -----------------------------------------------------------------------------
module dir_mapp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        read_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit
);

  localparam int LINES = 32;

  logic [4:0]       idx;
  logic [26:0]      tag;
  logic             wr_en;
  logic             rd_en;
  logic             lookup_hit;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [31:0]      data_out_q;
  logic [31:0]      data_out_d;
  logic             hit_q;
  logic             hit_d;

  // Tag/data storage carries no reset: a cleared valid bit is enough to make
  // a line miss, so stale contents are never observed.
  logic [26:0]      tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  assign idx   = data_in[4:0];
  assign tag   = data_in[31:5];
  assign wr_en = enable & read_write;
  assign rd_en = enable & ~read_write;

  // The tag compare has to happen in the same cycle as the request, so the
  // arrays are read combinationally and only the result is registered.
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    valid_d    = valid_q;
    data_out_d = data_out_q;
    hit_d      = hit_q;
    if (wr_en) begin
      valid_d[idx] = 1'b1;
    end
    if (rd_en) begin
      hit_d      = lookup_hit;
      data_out_d = lookup_hit ? data_mem[idx] : 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      data_out_q <= 32'h0000_0000;
      hit_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
      hit_q      <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign hit      = hit_q;

endmodule

// File: tb/tb_dir_mapp.sv
// -----------------------------------------------------------------------------
// tb_dir_mapp : self-checking bench for dir_mapp.
// A behavioural model (array of stored words plus valid flags) predicts the
// outputs; a compare process checks them on every falling clock edge, and
// directed sequences add literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_dir_mapp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        read_write;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  dir_mapp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .read_write (read_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid [32];
  logic [31:0] m_word  [32];
  logic [31:0] m_dout;
  logic        m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_dout = 32'h0;
      m_hit  = 1'b0;
    end else if (enable) begin
      int line;
      line = int'(data_in % 32);
      if (read_write) begin
        m_valid[line] = 1'b1;
        m_word[line]  = data_in;
      end else if (m_valid[line] && (m_word[line] / 32 == data_in / 32)) begin
        m_dout = m_word[line];
        m_hit  = 1'b1;
      end else begin
        m_dout = 32'h0;
        m_hit  = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if (data_out !== m_dout || hit !== m_hit) begin
        n_bad++;
        $display("FAIL model t=%0t: data_out=%h hit=%b, required data_out=%h hit=%b",
                 $time, data_out, hit, m_dout, m_hit);
      end
    end
  end

  // ---------------- helpers ----------------
  // Drive one operation just after the falling edge; it is taken on the next
  // rising edge.
  task automatic step(input logic en, input logic rw, input logic [31:0] din);
    @(negedge clk);
    #1;
    enable     = en;
    read_write = rw;
    data_in    = din;
  endtask

  task automatic check_lit(input string name, input logic [31:0] exp_d, input logic exp_h);
    n_cmp++;
    if (data_out !== exp_d || hit !== exp_h) begin
      n_bad++;
      $display("FAIL %s: data_out=%h hit=%b, required data_out=%h hit=%b",
               name, data_out, hit, exp_d, exp_h);
    end else begin
      $display("ok   %s: data_out=%h hit=%b", name, data_out, hit);
    end
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [26:0] t;
    logic [4:0]  ix;
    t  = 27'(i * 7 + 1);
    ix = 5'(i);
    return {t, ix};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    enable     = 1'b0;
    read_write = 1'b0;
    data_in    = 32'h0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    chk_on     = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check_lit("reset_state", 32'h0, 1'b0);

    // Cold read misses
    step(1'b1, 1'b0, 32'h0000_0005);
    step(1'b0, 1'b0, 32'h0);
    check_lit("cold_read_miss", 32'h0, 1'b0);

    // Write then immediate read of same index
    step(1'b1, 1'b1, 32'h1234_5683);
    step(1'b1, 1'b0, 32'h1234_5683);
    step(1'b0, 1'b0, 32'h0);
    check_lit("write_then_read_hit", 32'h1234_5683, 1'b1);

    // Eviction on index 3
    step(1'b1, 1'b1, 32'h0000_0023);
    step(1'b1, 1'b1, 32'h0000_0043);
    step(1'b1, 1'b0, 32'h0000_0023);
    step(1'b1, 1'b0, 32'h0000_0043);
    check_lit("evicted_read_miss", 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_lit("evictor_read_hit", 32'h0000_0043, 1'b1);

    // Fill all 32 lines, then read them back-to-back
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, fill_word(i));
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, fill_word(i));
      if (i > 0) check_lit($sformatf("sweep_read_%0d", i - 1), fill_word(i - 1), 1'b1);
    end
    step(1'b0, 1'b0, 32'h0);
    check_lit("sweep_read_31", fill_word(31), 1'b1);

    // Idle cycles with changing inputs: outputs hold
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check_lit("idle_hold_1", fill_word(31), 1'b1);
    step(1'b0, 1'b0, 32'h0000_0000);
    check_lit("idle_hold_2", fill_word(31), 1'b1);
    step(1'b0, 1'b0, 32'hFFFF_FFFF);
    check_lit("idle_hold_3", fill_word(31), 1'b1);

    // A write does not disturb the outputs
    step(1'b1, 1'b1, 32'hABCD_E007);
    step(1'b0, 1'b0, 32'h0);
    check_lit("write_holds_outputs", fill_word(31), 1'b1);

    // Tag mismatch on a valid line misses
    step(1'b1, 1'b0, 32'hABCD_E027);
    step(1'b0, 1'b0, 32'h0);
    check_lit("tag_mismatch_miss", 32'h0, 1'b0);

    // Async reset pulse between edges after a hit
    step(1'b1, 1'b0, 32'hABCD_E007);
    step(1'b0, 1'b0, 32'h0);
    check_lit("pre_reset_hit", 32'hABCD_E007, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_lit("async_reset_outputs", 32'h0, 1'b0);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 32'hABCD_E007);
    step(1'b1, 1'b0, fill_word(0));
    check_lit("post_reset_read_miss", 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_lit("post_reset_other_miss", 32'h0, 1'b0);

    // Refill after reset works again
    step(1'b1, 1'b1, 32'hABCD_E007);
    step(1'b1, 1'b0, 32'hABCD_E007);
    step(1'b0, 1'b0, 32'h0);
    check_lit("refill_after_reset_hit", 32'hABCD_E007, 1'b1);

    // Mixed directed traffic, checked by the model only
    step(1'b1, 1'b1, 32'h8000_001F);
    step(1'b1, 1'b0, 32'h8000_001F);
    step(1'b1, 1'b0, 32'h0000_001F);
    step(1'b1, 1'b1, 32'h0000_001F);
    step(1'b1, 1'b0, 32'h0000_001F);
    step(1'b1, 1'b0, 32'h8000_001F);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
